// File: rtl/y86_fetch_aligner.sv
// Y86-64 fetch aligner: circular byte queue of memory beats, pops one decoded instruction per handshake.
// Optional Y86_ALIGN_HALT_LOCK_EN: halt/invalid pops lock the queue until flush or rst.
module y86_fetch_aligner #(
    parameter int FETCH_BYTES = 8,
    parameter int BUF_BYTES   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*FETCH_BYTES-1:0] in_data,
    input  logic                     flush,
    input  logic [63:0]              flush_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               icode,
    output logic [3:0]               ifun,
    output logic [3:0]               rA,
    output logic [3:0]               rB,
    output logic [63:0]              valC,
    output logic [63:0]              valP,
    output logic                     instr_valid
);

    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FREE_LIM = CNT_W'(BUF_BYTES - FETCH_BYTES);
    localparam logic [CNT_W-1:0] BEAT_CNT = CNT_W'(FETCH_BYTES);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    logic [7:0]       mem_q [BUF_BYTES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      pc_q, pc_d;
    state_t           state_q, state_d;

    logic [7:0]       hb [10];
    logic [3:0]       hd_icode;
    logic [3:0]       len;
    logic             has_reg;
    logic             has_c;
    logic             ok;
    logic             run;
    logic             push;
    logic             pop;
    logic [63:0]      next_pc;
    logic [63:0]      cval;
    logic [PTR_W-1:0] wr_base;

    // Window of the ten bytes at the head; the longest instruction is 10 bytes.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            hb[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    assign hd_icode = hb[0][7:4];

    always_comb begin
        len     = 4'd1;
        has_reg = 1'b0;
        has_c   = 1'b0;
        ok      = 1'b1;
        case (hd_icode)
            4'h0, 4'h1, 4'h9: len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            4'h3, 4'h4, 4'h5: begin
                len     = 4'd10;
                has_reg = 1'b1;
                has_c   = 1'b1;
            end
            4'h7, 4'h8: begin
                len   = 4'd9;
                has_c = 1'b1;
            end
            default: ok = 1'b0;
        endcase
    end

    assign cval = has_reg
        ? {hb[9], hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2]}
        : {hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2], hb[1]};

    assign run       = (state_q == S_RUN);
    assign next_pc   = pc_q + 64'(len);
    assign out_valid = run && (count_q != '0) && (count_q >= CNT_W'(len));
    assign in_ready  = run && !rst && (count_q <= FREE_LIM);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_base   = head_q + count_q[PTR_W-1:0];

    always_comb begin
        icode       = 4'h0;
        ifun        = 4'h0;
        rA          = 4'hF;
        rB          = 4'hF;
        valC        = 64'h0;
        valP        = pc_q;
        instr_valid = 1'b0;
        if (out_valid) begin
            icode       = hb[0][7:4];
            ifun        = hb[0][3:0];
            valP        = next_pc;
            instr_valid = ok;
            if (has_reg) begin
                rA = hb[1][7:4];
                rB = hb[1][3:0];
            end
            if (has_c) begin
                valC = cval;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        pc_d    = pc_q;
        state_d = state_q;
        if (flush) begin
            head_d  = '0;
            count_d = '0;
            pc_d    = flush_pc;
            state_d = S_RUN;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_W'(len);
                pc_d   = next_pc;
`ifdef Y86_ALIGN_HALT_LOCK_EN
                if (hd_icode == 4'h0 || !ok) begin
                    state_d = S_HALTED;
                end
`endif
            end
            count_d = count_q
                    + (push ? BEAT_CNT : '0)
                    - (pop ? CNT_W'(len) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            count_q <= '0;
            pc_q    <= 64'h0;
            state_q <= S_RUN;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // Queue storage carries no reset; count alone decides which bytes are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                mem_q[wr_base + PTR_W'(k)] <= in_data[8*k +: 8];
            end
        end
    end

endmodule

// File: doc/y86_fetch_aligner.md
# y86_fetch_aligner

Parametrised fetch-stage byte aligner for the pipelined Y86-64 core. It accepts fixed-width instruction-memory beats into a circular byte queue and pops one whole variable-length instruction per handshake. Each popped instruction is presented pre-split as icode/ifun/rA/rB/valC plus valP. It sits between instruction memory and the F/D pipeline register, and the decode stage stalls it through `out_ready`.

## Interface
- `FETCH_BYTES`, 8: bytes delivered per input beat; 1–16.
- `BUF_BYTES`, 32: queue capacity in bytes; power of two, ≥ `FETCH_BYTES`+9.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  beat on `in_data` is valid.
- `in_ready`  out  1  queue can take a full beat.
- `in_data`  in  8*FETCH_BYTES  beat; byte k = `in_data[8k+7:8k]`, byte 0 = lowest address.
- `flush`  in  1  discard queue and restart at `flush_pc` (mispredict/redirect).
- `flush_pc`  in  64  new PC.
- `out_valid`  out  1  complete instruction at queue head.
- `out_ready`  in  1  downstream takes instruction.
- `icode`, `ifun`  out  4 each  head byte [7:4], [3:0].
- `rA`, `rB`  out  4 each  register byte [7:4], [3:0]; 4'hF when no register byte.
- `valC`  out  64  little-endian constant; 0 when none.
- `valP`  out  64  PC + instruction length.
- `instr_valid`  out  1  icode in 0x0–0xB.

## Operation
- Lengths by icode: 0,1,9 → 1; 2,6,A,B → 2; 3,4,5 → 10; 7,8 → 9; C–F → 1 with `instr_valid`=0.
- Register byte present for 2,3,4,5,6,A,B. valC comes from bytes 2–9 when the register byte is present (3,4,5) and from bytes 1–8 otherwise (7,8).
- State: `head` (log2 BUF_BYTES bits), `count` (0..BUF_BYTES), `pc` (64), FSM {RUN, HALTED}.
- `in_ready` = (state==RUN) && !rst && (count ≤ BUF_BYTES−FETCH_BYTES). Evaluated on the current count, before any same-cycle pop.
- Push: `in_valid && in_ready` writes FETCH_BYTES bytes at (head+count) mod BUF_BYTES, wrapping across the buffer end.
- `out_valid` = (state==RUN) && count≥1 && count ≥ len(head icode). Fields are combinational from the queue head.
- Pop: `out_valid && out_ready` sets head += len (mod BUF_BYTES) and `pc` ← valP.
- Push and pop in the same cycle: count' = count + FETCH_BYTES − len.
- Flush has priority over push and pop in the same cycle. Next edge: count=0, head=0, pc=flush_pc, state=RUN; the beat offered that cycle is dropped.
- valP = pc + len, mod 2^64 (wraps silently).
- When `out_valid`=0: icode=ifun=0, rA=rB=4'hF, valC=0, valP=pc, `instr_valid`=0.

## Timing
- Reset values: count=0, head=0, pc=0, state=RUN, `out_valid`=0, `in_ready`=0 during rst and 1 in the first cycle after.
- Latency: a beat accepted at edge N can produce `out_valid`=1 in the cycle after edge N.
- Throughput: one instruction per cycle while count ≥ len.
- `out_valid` never drops without a pop, flush or rst. Fields stay stable while `out_valid && !out_ready`.
- Full: count > BUF_BYTES−FETCH_BYTES deasserts `in_ready`. Partial beats are never accepted.
- Partial instruction: count < len holds `out_valid`=0 until enough bytes arrive. Forward progress is guaranteed by the BUF_BYTES constraint.
- rst asserted mid-operation: all state returns to reset values at that edge; in-flight bytes are lost.

## Configuration
- `Y86_ALIGN_HALT_LOCK_EN` defined: popping icode 0 (halt) or any invalid icode moves FSM RUN→HALTED. In HALTED, `out_valid`=0 and `in_ready`=0 until flush or rst.
- Not defined: FSM stays in RUN; halt and invalid instructions pop like any other.

## Test plan
- FETCH_BYTES=8. Beat 0x…_00000000_0000000A_F030 (irmovq $10,%rax) with pc=0 → a second beat is needed (count 8 < 10); then out icode=3, rA=F, rB=0, valC=10, valP=10.
- Stream of 2-byte `6000` (addq) in 8-byte beats with `out_ready`=1 → 4 pops per beat, valP = 2, 4, 6, 8…, continuous `out_valid`.
- BUF_BYTES=32, `out_ready`=0, keep feeding → `in_ready` falls once count=32 (after 4 beats). Release → pops resume and the wrapped bytes decode correctly.
- Push and pop in the same cycle at count=24 with a 2-byte instruction → count=30 next cycle.
- Flush with flush_pc=0x100 while `in_valid`=1 → next cycle count=0, `out_valid`=0, and the first instruction after refill has valP=0x100+len.
- With `Y86_ALIGN_HALT_LOCK_EN`: pop byte 0x00 → `out_valid`=0 and `in_ready`=0 until flush. Without it: the following nop pops on the next cycle.
